// File: rtl/aos_sr_read_scheduler.sv
// Host-to-route-tree SoftReg sequencer: queues host requests, forwards them one at a time, keeps one read in flight.
// Optional read timeout with DRAIN recovery and sticky per-app flags is enabled by defining AOS_SR_TIMEOUT_EN.
module aos_sr_read_scheduler #(
   parameter int          SR_NUM_APPS    = 2,
   parameter int          FIFO_LOG_DEPTH = 2,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [63:0] TIMEOUT_DATA   = 64'hDEAD_DEAD_DEAD_DEAD,
   parameter logic [63:0] DISABLED_DATA  = 64'hD15A_B1ED_D15A_B1ED
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [SR_NUM_APPS-1:0] app_enable,
   input  logic                   host_req_valid,
   input  logic                   host_req_is_write,
   input  logic [31:0]            host_req_addr,
   input  logic [63:0]            host_req_data,
   output logic                   host_resp_valid,
   output logic [63:0]            host_resp_data,
   output logic                   tree_req_valid,
   output logic                   tree_req_is_write,
   output logic [31:0]            tree_req_addr,
   output logic [63:0]            tree_req_data,
   input  logic                   tree_resp_valid,
   input  logic [63:0]            tree_resp_data,
   output logic [SR_NUM_APPS-1:0] timeout_flags,
   output logic [7:0]             drop_count,
   output logic                   busy
);

   // state     | meaning
   // IDLE      | pop one queued request per cycle
   // WAIT_RESP | read outstanding, waiting for the tree (or the deadline)
   // DRAIN     | read timed out, swallowing its late response
   typedef enum logic [1:0] {IDLE, WAIT_RESP, DRAIN} state_t;

   localparam int IDX_W = (SR_NUM_APPS > 1) ? $clog2(SR_NUM_APPS) : 1;
   localparam int DEPTH = 1 << FIFO_LOG_DEPTH;
   localparam int PTR_W = FIFO_LOG_DEPTH + 1;
   localparam int ENT_W = 1 + 32 + 64;

   state_t state_q, state_d;

   logic [ENT_W-1:0] fifo_mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             fifo_empty, fifo_full, push;

   logic [ENT_W-1:0] head;
   logic             head_is_write;
   logic [31:0]      head_addr;
   logic [63:0]      head_data;
   logic [IDX_W-1:0] head_idx;
   logic             head_en;

   logic        host_resp_valid_q, host_resp_valid_d;
   logic [63:0] host_resp_data_q, host_resp_data_d;
   logic        tree_req_valid_q, tree_req_valid_d;
   logic        tree_req_is_write_q, tree_req_is_write_d;
   logic [31:0] tree_req_addr_q, tree_req_addr_d;
   logic [63:0] tree_req_data_q, tree_req_data_d;
   logic [7:0]  drop_count_q, drop_count_d;
   logic [8:0]  drop_sum;
   logic        ovf_drop, unsol_drop;

`ifdef AOS_SR_TIMEOUT_EN
   localparam int               TMR_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_TC = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0]       timer_q, timer_d;
   logic [IDX_W-1:0]       app_idx_q, app_idx_d;
   logic [SR_NUM_APPS-1:0] flags_q, flags_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (^TIMEOUT_DATA) ^ (TIMEOUT_CYCLES == 0);
`endif

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                       (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
   assign push       = host_req_valid && !fifo_full;

   assign head          = fifo_mem_q[rd_ptr_q[PTR_W-2:0]];
   assign head_is_write = head[ENT_W-1];
   assign head_addr     = head[95:64];
   assign head_data     = head[63:0];
   assign head_idx      = head_addr[10 +: IDX_W];

   // Out-of-range indices match no slot and therefore read as disabled.
   always_comb begin
      head_en = 1'b0;
      for (int i = 0; i < SR_NUM_APPS; i++) begin
         if (head_idx == IDX_W'(i)) head_en = app_enable[i];
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q[PTR_W-2:0]] <= {host_req_is_write, host_req_addr, host_req_data};
   end

   assign ovf_drop   = host_req_valid && fifo_full;
   assign unsol_drop = tree_resp_valid && (state_q == IDLE);
   assign drop_sum   = {1'b0, drop_count_q} + 9'(ovf_drop) + 9'(unsol_drop);

   always_comb begin
      state_d             = state_q;
      wr_ptr_d            = wr_ptr_q + PTR_W'(push);
      rd_ptr_d            = rd_ptr_q;
      host_resp_valid_d   = 1'b0;
      host_resp_data_d    = '0;
      tree_req_valid_d    = 1'b0;
      tree_req_is_write_d = 1'b0;
      tree_req_addr_d     = '0;
      tree_req_data_d     = '0;
      drop_count_d        = drop_sum[8] ? 8'hFF : drop_sum[7:0];
`ifdef AOS_SR_TIMEOUT_EN
      timer_d             = timer_q;
      app_idx_d           = app_idx_q;
      flags_d             = flags_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
               if (head_en) begin
                  tree_req_valid_d    = 1'b1;
                  tree_req_is_write_d = head_is_write;
                  tree_req_addr_d     = head_addr;
                  tree_req_data_d     = head_data;
                  if (!head_is_write) begin
                     state_d = WAIT_RESP;
`ifdef AOS_SR_TIMEOUT_EN
                     timer_d   = '0;
                     app_idx_d = head_idx;
`endif
                  end
               end else if (!head_is_write) begin
                  host_resp_valid_d = 1'b1;
                  host_resp_data_d  = DISABLED_DATA;
               end
            end
         end
         WAIT_RESP: begin
            if (tree_resp_valid) begin
               host_resp_valid_d = 1'b1;
               host_resp_data_d  = tree_resp_data;
               state_d           = IDLE;
            end
`ifdef AOS_SR_TIMEOUT_EN
            else if (timer_q == TMR_TC) begin
               host_resp_valid_d = 1'b1;
               host_resp_data_d  = TIMEOUT_DATA;
               timer_d           = '0;
               state_d           = DRAIN;
               for (int i = 0; i < SR_NUM_APPS; i++) begin
                  if (app_idx_q == IDX_W'(i)) flags_d[i] = 1'b1;
               end
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
`endif
         end
`ifdef AOS_SR_TIMEOUT_EN
         DRAIN: begin
            if (tree_resp_valid || (timer_q == TMR_TC)) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q             <= IDLE;
         wr_ptr_q            <= '0;
         rd_ptr_q            <= '0;
         host_resp_valid_q   <= 1'b0;
         host_resp_data_q    <= '0;
         tree_req_valid_q    <= 1'b0;
         tree_req_is_write_q <= 1'b0;
         tree_req_addr_q     <= '0;
         tree_req_data_q     <= '0;
         drop_count_q        <= '0;
      end else begin
         state_q             <= state_d;
         wr_ptr_q            <= wr_ptr_d;
         rd_ptr_q            <= rd_ptr_d;
         host_resp_valid_q   <= host_resp_valid_d;
         host_resp_data_q    <= host_resp_data_d;
         tree_req_valid_q    <= tree_req_valid_d;
         tree_req_is_write_q <= tree_req_is_write_d;
         tree_req_addr_q     <= tree_req_addr_d;
         tree_req_data_q     <= tree_req_data_d;
         drop_count_q        <= drop_count_d;
      end
   end

`ifdef AOS_SR_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q   <= '0;
         app_idx_q <= '0;
         flags_q   <= '0;
      end else begin
         timer_q   <= timer_d;
         app_idx_q <= app_idx_d;
         flags_q   <= flags_d;
      end
   end

   assign timeout_flags = flags_q;
`else
   assign timeout_flags = '0;
`endif

   assign host_resp_valid   = host_resp_valid_q;
   assign host_resp_data    = host_resp_data_q;
   assign tree_req_valid    = tree_req_valid_q;
   assign tree_req_is_write = tree_req_is_write_q;
   assign tree_req_addr     = tree_req_addr_q;
   assign tree_req_data     = tree_req_data_q;
   assign drop_count        = drop_count_q;
   assign busy              = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_aos_sr_read_scheduler.sv
// Directed bench for aos_sr_read_scheduler (TIMEOUT_CYCLES=16); the timeout scenario follows AOS_SR_TIMEOUT_EN.
module tb_aos_sr_read_scheduler;

   localparam logic [63:0] TO_DATA  = 64'hDEAD_DEAD_DEAD_DEAD;
   localparam logic [63:0] DIS_DATA = 64'hD15A_B1ED_D15A_B1ED;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  app_enable = 2'b11;
   logic        host_req_valid = 1'b0;
   logic        host_req_is_write = 1'b0;
   logic [31:0] host_req_addr = '0;
   logic [63:0] host_req_data = '0;
   logic        host_resp_valid;
   logic [63:0] host_resp_data;
   logic        tree_req_valid;
   logic        tree_req_is_write;
   logic [31:0] tree_req_addr;
   logic [63:0] tree_req_data;
   logic        tree_resp_valid = 1'b0;
   logic [63:0] tree_resp_data = '0;
   logic [1:0]  timeout_flags;
   logic [7:0]  drop_count;
   logic        busy;

   int errors = 0;
   int checks = 0;

   aos_sr_read_scheduler #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .app_enable(app_enable),
      .host_req_valid(host_req_valid), .host_req_is_write(host_req_is_write),
      .host_req_addr(host_req_addr), .host_req_data(host_req_data),
      .host_resp_valid(host_resp_valid), .host_resp_data(host_resp_data),
      .tree_req_valid(tree_req_valid), .tree_req_is_write(tree_req_is_write),
      .tree_req_addr(tree_req_addr), .tree_req_data(tree_req_data),
      .tree_resp_valid(tree_resp_valid), .tree_resp_data(tree_resp_data),
      .timeout_flags(timeout_flags), .drop_count(drop_count), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host(input logic v, input logic w, input logic [31:0] a, input logic [63:0] d);
      host_req_valid    = v;
      host_req_is_write = w;
      host_req_addr     = a;
      host_req_data     = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      checks++; if (host_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_host_resp: got %b want 0", host_resp_valid); end
      checks++; if (tree_req_valid !== 1'b0) begin errors++; $display("FAIL reset_tree_req: got %b want 0", tree_req_valid); end
      checks++; if (timeout_flags !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", timeout_flags); end
      checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
      rst_n = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_write_read();
      host(1, 1, 32'h0404, 64'h55);
      tick();
      host(1, 0, 32'h0408, 64'h0);
      checks++; if (tree_req_valid !== 1'b0) begin errors++; $display("FAIL wr_early: got %b want 0", tree_req_valid); end
      tick();
      host(0, 0, 32'h0, 64'h0);
      checks++; if ({tree_req_valid, tree_req_is_write, tree_req_addr, tree_req_data} !== {1'b1, 1'b1, 32'h0404, 64'h55}) begin
         errors++; $display("FAIL wr_req: got v=%b w=%b a=%h d=%h want v=1 w=1 a=00000404 d=55", tree_req_valid, tree_req_is_write, tree_req_addr, tree_req_data);
      end
      tick();
      checks++; if ({tree_req_valid, tree_req_is_write, tree_req_addr} !== {1'b1, 1'b0, 32'h0408}) begin
         errors++; $display("FAIL rd_req: got v=%b w=%b a=%h want v=1 w=0 a=00000408", tree_req_valid, tree_req_is_write, tree_req_addr);
      end
      tick();
      checks++; if (tree_req_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rd_wait: got treq=%b busy=%b want 0 1", tree_req_valid, busy); end
      tick(); tick();
      tree_resp_valid = 1'b1; tree_resp_data = 64'hABCD;
      checks++; if (host_resp_valid !== 1'b0) begin errors++; $display("FAIL rd_resp_early: got %b want 0", host_resp_valid); end
      tick();
      tree_resp_valid = 1'b0; tree_resp_data = '0;
      checks++; if (host_resp_valid !== 1'b1 || host_resp_data !== 64'hABCD) begin
         errors++; $display("FAIL rd_resp: got v=%b d=%h want 1 abcd", host_resp_valid, host_resp_data);
      end
      tick();
      checks++; if (host_resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_resp_pulse: got v=%b busy=%b want 0 0", host_resp_valid, busy); end
   endtask

   task automatic test_disabled();
      app_enable = 2'b01;
      host(1, 0, 32'h0400, 64'h0);
      tick();
      host(1, 1, 32'h0400, 64'h12);
      checks++; if (host_resp_valid !== 1'b0) begin errors++; $display("FAIL dis_early: got %b want 0", host_resp_valid); end
      tick();
      host(0, 0, 32'h0, 64'h0);
      checks++; if (host_resp_valid !== 1'b1 || host_resp_data !== DIS_DATA || tree_req_valid !== 1'b0) begin
         errors++; $display("FAIL dis_read: got v=%b d=%h treq=%b want 1 %h 0", host_resp_valid, host_resp_data, tree_req_valid, DIS_DATA);
      end
      tick();
      checks++; if (host_resp_valid !== 1'b0 || tree_req_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL dis_write: got resp=%b treq=%b busy=%b want 0 0 0", host_resp_valid, tree_req_valid, busy);
      end
      app_enable = 2'b11;
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      host(1, 0, 32'h0000, 64'h0);
      tick();
      host(0, 0, 32'h0, 64'h0);
      tick();
      checks++; if (tree_req_valid !== 1'b1) begin errors++; $display("FAIL to_req: got %b want 1", tree_req_valid); end
`ifdef AOS_SR_TIMEOUT_EN
      for (int k = 1; k < 16; k++) begin
         tick();
         if (host_resp_valid !== 1'b0) early++;
      end
      checks++; if (early !== 0) begin errors++; $display("FAIL to_early: got %0d early responses want 0", early); end
      tick();
      checks++; if (host_resp_valid !== 1'b1 || host_resp_data !== TO_DATA || timeout_flags !== 2'b01) begin
         errors++; $display("FAIL to_resp: got v=%b d=%h flags=%b want 1 %h 01", host_resp_valid, host_resp_data, timeout_flags, TO_DATA);
      end
      tick(); tick(); tick(); tick();
      tree_resp_valid = 1'b1; tree_resp_data = 64'h1234;
      tick();
      tree_resp_valid = 1'b0; tree_resp_data = '0;
      checks++; if (host_resp_valid !== 1'b0 || drop_count !== 8'd0 || busy !== 1'b0 || timeout_flags !== 2'b01) begin
         errors++; $display("FAIL to_late: got resp=%b drop=%0d busy=%b flags=%b want 0 0 0 01", host_resp_valid, drop_count, busy, timeout_flags);
      end
`else
      for (int k = 1; k < 40; k++) begin
         tick();
         if (host_resp_valid !== 1'b0 || busy !== 1'b1) early++;
      end
      checks++; if (early !== 0) begin errors++; $display("FAIL nto_wait: got %0d bad cycles want 0", early); end
      tree_resp_valid = 1'b1; tree_resp_data = 64'h4321;
      tick();
      tree_resp_valid = 1'b0; tree_resp_data = '0;
      checks++; if (host_resp_valid !== 1'b1 || host_resp_data !== 64'h4321 || timeout_flags !== 2'b00) begin
         errors++; $display("FAIL nto_resp: got v=%b d=%h flags=%b want 1 4321 00", host_resp_valid, host_resp_data, timeout_flags);
      end
      tick();
      checks++; if (busy !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL nto_idle: got busy=%b drop=%0d want 0 0", busy, drop_count); end
`endif
   endtask

   task automatic test_fifo_full();
      host(1, 0, 32'h0400, 64'h0);
      tick();
      host(0, 0, 32'h0, 64'h0);
      tick();
      for (int i = 0; i < 6; i++) begin
         host(1, 1, 32'h0400 + 32'(i * 8), 64'(i));
         tick();
      end
      host(0, 0, 32'h0, 64'h0);
      checks++; if (drop_count !== 8'd2 || tree_req_valid !== 1'b0) begin
         errors++; $display("FAIL full_drop: got drop=%0d treq=%b want 2 0", drop_count, tree_req_valid);
      end
      tree_resp_valid = 1'b1; tree_resp_data = 64'h77;
      tick();
      tree_resp_valid = 1'b0; tree_resp_data = '0;
      checks++; if (host_resp_valid !== 1'b1 || host_resp_data !== 64'h77) begin
         errors++; $display("FAIL full_resp: got v=%b d=%h want 1 77", host_resp_valid, host_resp_data);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if ({tree_req_valid, tree_req_addr, tree_req_data} !== {1'b1, 32'h0400 + 32'(i * 8), 64'(i)}) begin
            errors++; $display("FAIL full_order%0d: got v=%b a=%h d=%h want 1 %h %h", i, tree_req_valid, tree_req_addr, tree_req_data, 32'h0400 + 32'(i * 8), 64'(i));
         end
      end
      tick();
      checks++; if (tree_req_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL full_tail: got treq=%b busy=%b want 0 0", tree_req_valid, busy); end
   endtask

   task automatic test_saturate();
      tree_resp_valid = 1'b1;
      for (int i = 0; i < 100; i++) tick();
      checks++; if (drop_count !== 8'd102) begin errors++; $display("FAIL sat_mid: got %0d want 102", drop_count); end
      for (int i = 0; i < 153; i++) tick();
      checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_edge: got %0d want 255", drop_count); end
      for (int i = 0; i < 47; i++) tick();
      tree_resp_valid = 1'b0;
      tick();
      checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", drop_count); end
   endtask

   task automatic test_reset_mid_read();
      host(1, 0, 32'h0000, 64'h0);
      tick();
      host(0, 0, 32'h0, 64'h0);
      tick();
      checks++; if (tree_req_valid !== 1'b1) begin errors++; $display("FAIL rst_pre: got %b want 1", tree_req_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if ({tree_req_valid, host_resp_valid, busy, drop_count, timeout_flags} !== 13'd0) begin
         errors++; $display("FAIL rst_async: got treq=%b resp=%b busy=%b drop=%0d flags=%b want all 0", tree_req_valid, host_resp_valid, busy, drop_count, timeout_flags);
      end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      tree_resp_valid = 1'b1; tree_resp_data = 64'h5A;
      tick();
      tree_resp_valid = 1'b0; tree_resp_data = '0;
      checks++; if (drop_count !== 8'd1 || host_resp_valid !== 1'b0) begin
         errors++; $display("FAIL rst_late: got drop=%0d resp=%b want 1 0", drop_count, host_resp_valid);
      end
   endtask

   task automatic test_back_to_back();
      host(1, 0, 32'h0400, 64'h0);
      tick();
      host(0, 0, 32'h0, 64'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         host(1, 1, 32'h0000, 64'h10 + 64'(i));
         tick();
      end
      host(0, 0, 32'h0, 64'h0);
      tree_resp_valid = 1'b1; tree_resp_data = 64'h99;
      tick();
      host(1, 1, 32'h0000, 64'hEE);
      checks++; if (host_resp_valid !== 1'b1 || host_resp_data !== 64'h99) begin
         errors++; $display("FAIL b2b_resp: got v=%b d=%h want 1 99", host_resp_valid, host_resp_data);
      end
      tick();
      host(0, 0, 32'h0, 64'h0);
      tree_resp_valid = 1'b0; tree_resp_data = '0;
      checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL b2b_double_drop: got %0d want 3", drop_count); end
      for (int i = 0; i < 4; i++) begin
         checks++; if ({tree_req_valid, tree_req_is_write, tree_req_data} !== {1'b1, 1'b1, 64'h10 + 64'(i)}) begin
            errors++; $display("FAIL b2b_wr%0d: got v=%b w=%b d=%h want 1 1 %h", i, tree_req_valid, tree_req_is_write, tree_req_data, 64'h10 + 64'(i));
         end
         tick();
      end
      checks++; if (tree_req_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_tail: got treq=%b busy=%b want 0 0", tree_req_valid, busy); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_disabled();
      test_timeout();
      test_fifo_full();
      test_saturate();
      test_reset_mid_read();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
